// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: per-register in-flight writer counts driving decode stall, bubble and squash correction.
module reg_scoreboard_ctrl #(
    parameter int NREGS = 32,
    parameter int CNT_W = 2,
    parameter bit WB_BYPASS = 1'b0,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid_inst,
    input  logic [4:0]             id_rs1_idx,
    input  logic [4:0]             id_rs2_idx,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic                   id_reg_wr,
    input  logic [4:0]             id_dest_reg_idx,
    input  logic                   squash,
    input  logic                   id_ex_reg_wr,
    input  logic [4:0]             id_ex_dest_reg_idx,
    input  logic                   mem_wb_valid_inst,
    input  logic                   mem_wb_reg_wr,
    input  logic [4:0]             mem_wb_dest_reg_idx,
    output logic                   stall,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_bubble,
    output logic [NREGS-1:0]       pending_mask,
    output logic                   sb_overflow,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    localparam logic [CNT_W+1:0] MAXW = (CNT_W+2)'((1 << CNT_W) - 1);
    logic [CNT_W-1:0] count [NREGS];
    logic [CNT_W-1:0] cnt_next [NREGS];
    logic [NREGS-1:0] ovf_hit;
    logic [NREGS-1:0] under_hit;
    logic [CNT_W+1:0] ext;
    logic [CNT_W+1:0] dec;
    logic retire;
    logic kill;
    logic issue;
    logic busy1;
    logic busy2;
    logic hazard;
    assign retire = mem_wb_valid_inst && mem_wb_reg_wr && mem_wb_dest_reg_idx != '0;
    assign kill = squash && id_ex_reg_wr && id_ex_dest_reg_idx != '0;
    // With write-through, a register whose last in-flight writer retires this cycle is already readable.
    assign busy1 = id_rs1_idx != '0 && count[id_rs1_idx] != '0 &&
                   !(WB_BYPASS && retire && mem_wb_dest_reg_idx == id_rs1_idx && count[id_rs1_idx] == CNT_W'(1));
    assign busy2 = id_rs2_idx != '0 && count[id_rs2_idx] != '0 &&
                   !(WB_BYPASS && retire && mem_wb_dest_reg_idx == id_rs2_idx && count[id_rs2_idx] == CNT_W'(1));
    assign hazard = id_valid_inst && ((id_uses_rs1 && busy1) || (id_uses_rs2 && busy2));
    assign stall = !rst && hazard && !squash;
    assign pc_en = !stall;
    assign if_id_en = !stall;
    assign id_ex_bubble = !rst && (stall || squash);
    assign issue = id_valid_inst && id_reg_wr && id_dest_reg_idx != '0 && !stall && !squash;
    always_comb begin
        ext = '0;
        dec = '0;
        ovf_hit = '0;
        under_hit = '0;
        pending_mask = '0;
        for (int i = 0; i < NREGS; i++) begin
            ext = {2'b00, count[i]} + {{(CNT_W+1){1'b0}}, issue && id_dest_reg_idx == 5'(i)};
            dec = {{(CNT_W+1){1'b0}}, retire && mem_wb_dest_reg_idx == 5'(i)} +
                  {{(CNT_W+1){1'b0}}, kill && id_ex_dest_reg_idx == 5'(i)};
            under_hit[i] = ext < dec;
            ovf_hit[i] = !under_hit[i] && (ext - dec > MAXW);
            cnt_next[i] = (i == 0 || under_hit[i]) ? '0 : ovf_hit[i] ? '1 : CNT_W'(ext - dec);
            pending_mask[i] = i != 0 && count[i] != '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '{default: '0};
            sb_overflow <= 1'b0;
            stall_cycles <= '0;
        end else begin
            count <= cnt_next;
            sb_overflow <= sb_overflow || |ovf_hit;
            if (stall) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
        end
    end
    // A decrement with nothing in flight means the pipeline retired or killed a writer it never issued.
    assert property (@(posedge clk) disable iff (rst) under_hit == '0);
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// tb_reg_scoreboard_ctrl: table-driven scenarios with a queue of expected per-cycle observations.
module tb_reg_scoreboard_ctrl;
    typedef struct packed {
        logic rst, v;
        logic [4:0] rs1;
        logic u1;
        logic [4:0] rs2;
        logic u2, wr;
        logic [4:0] rd;
        logic sq, xwr;
        logic [4:0] xrd;
        logic wbv, wbwr;
        logic [4:0] wbrd;
    } stim_t;
    typedef struct packed {
        logic stall, bub, pc_en, if_id_en, ovf;
        logic [31:0] mask;
        logic [31:0] sc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid_inst = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_wr = 0;
    logic [4:0] id_rs1_idx = 0, id_rs2_idx = 0, id_dest_reg_idx = 0;
    logic squash = 0, id_ex_reg_wr = 0, mem_wb_valid_inst = 0, mem_wb_reg_wr = 0;
    logic [4:0] id_ex_dest_reg_idx = 0, mem_wb_dest_reg_idx = 0;
    logic stall, pc_en, if_id_en, id_ex_bubble, sb_overflow;
    logic stall_b, pc_en_b, if_id_en_b, id_ex_bubble_b, sb_overflow_b;
    logic [31:0] pending_mask, pending_mask_b, stall_cycles, stall_cycles_b;
    obs_t obs_a, obs_b;
    obs_t exp_q[$];
    obs_t expb_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard_ctrl #(.WB_BYPASS(1'b0)) dut (
        .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst), .id_rs1_idx(id_rs1_idx),
        .id_rs2_idx(id_rs2_idx), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_wr(id_reg_wr), .id_dest_reg_idx(id_dest_reg_idx), .squash(squash),
        .id_ex_reg_wr(id_ex_reg_wr), .id_ex_dest_reg_idx(id_ex_dest_reg_idx),
        .mem_wb_valid_inst(mem_wb_valid_inst), .mem_wb_reg_wr(mem_wb_reg_wr),
        .mem_wb_dest_reg_idx(mem_wb_dest_reg_idx), .stall(stall), .pc_en(pc_en),
        .if_id_en(if_id_en), .id_ex_bubble(id_ex_bubble), .pending_mask(pending_mask),
        .sb_overflow(sb_overflow), .stall_cycles(stall_cycles));

    reg_scoreboard_ctrl #(.WB_BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .id_valid_inst(id_valid_inst), .id_rs1_idx(id_rs1_idx),
        .id_rs2_idx(id_rs2_idx), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_wr(id_reg_wr), .id_dest_reg_idx(id_dest_reg_idx), .squash(squash),
        .id_ex_reg_wr(id_ex_reg_wr), .id_ex_dest_reg_idx(id_ex_dest_reg_idx),
        .mem_wb_valid_inst(mem_wb_valid_inst), .mem_wb_reg_wr(mem_wb_reg_wr),
        .mem_wb_dest_reg_idx(mem_wb_dest_reg_idx), .stall(stall_b), .pc_en(pc_en_b),
        .if_id_en(if_id_en_b), .id_ex_bubble(id_ex_bubble_b), .pending_mask(pending_mask_b),
        .sb_overflow(sb_overflow_b), .stall_cycles(stall_cycles_b));

    assign obs_a = {stall, id_ex_bubble, pc_en, if_id_en, sb_overflow, pending_mask, stall_cycles};
    assign obs_b = {stall_b, id_ex_bubble_b, pc_en_b, if_id_en_b, sb_overflow_b, pending_mask_b, stall_cycles_b};

    function automatic stim_t ins(input logic [4:0] r);
        stim_t s = '0; s.v = 1; s.wr = 1; s.rd = r; return s;
    endfunction
    function automatic stim_t rd1(input logic [4:0] r);
        stim_t s = '0; s.v = 1; s.rs1 = r; s.u1 = 1; return s;
    endfunction
    function automatic stim_t rd2(input logic [4:0] r);
        stim_t s = '0; s.v = 1; s.rs2 = r; s.u2 = 1; return s;
    endfunction
    function automatic stim_t nu1(input logic [4:0] r);
        stim_t s = '0; s.v = 1; s.rs1 = r; return s;
    endfunction
    function automatic stim_t sqk(input logic [4:0] r);
        stim_t s = '0; s.sq = 1; s.xwr = 1; s.xrd = r; return s;
    endfunction
    function automatic stim_t wb(input logic [4:0] r);
        stim_t s = '0; s.wbv = 1; s.wbwr = 1; s.wbrd = r; return s;
    endfunction
    function automatic stim_t rs();
        stim_t s = '0; s.rst = 1; return s;
    endfunction
    function automatic logic [31:0] m(input int r);
        return 32'd1 << r;
    endfunction
    function automatic obs_t ob(input logic st, input logic bub, input logic ovf,
                                input logic [31:0] mask, input logic [31:0] sc);
        return {st, bub, !st, !st, ovf, mask, sc};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; id_valid_inst = s.v; id_rs1_idx = s.rs1; id_uses_rs1 = s.u1;
        id_rs2_idx = s.rs2; id_uses_rs2 = s.u2; id_reg_wr = s.wr; id_dest_reg_idx = s.rd;
        squash = s.sq; id_ex_reg_wr = s.xwr; id_ex_dest_reg_idx = s.xrd;
        mem_wb_valid_inst = s.wbv; mem_wb_reg_wr = s.wbwr; mem_wb_dest_reg_idx = s.wbrd;
    endtask

    task automatic reset_quiet();
        @(posedge clk); #1; apply(rs());
    endtask

    task automatic test_reset();
        stim_t st[4];
        obs_t ea[4];
        obs_t e;
        st = '{rs(), rs(), '0, '0};
        for (int i = 0; i < 4; i++) ea[i] = ob(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(ea[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL reset[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL reset_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_raw();
        stim_t st[6];
        obs_t ea[6];
        obs_t eb[6];
        obs_t e;
        reset_quiet();
        st = '{ins(5) | rd1(0), rd1(3) | rd2(5), rd1(3) | rd2(5), rd1(3) | rd2(5) | wb(5), rd1(3) | rd2(5), '0};
        ea = '{ob(0, 0, 0, 0, 0), ob(1, 1, 0, m(5), 0), ob(1, 1, 0, m(5), 1),
               ob(1, 1, 0, m(5), 2), ob(0, 0, 0, 0, 3), ob(0, 0, 0, 0, 3)};
        eb = '{ob(0, 0, 0, 0, 0), ob(1, 1, 0, m(5), 0), ob(1, 1, 0, m(5), 1),
               ob(0, 0, 0, m(5), 2), ob(0, 0, 0, 0, 2), ob(0, 0, 0, 0, 2)};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(eb[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL raw[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL raw_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_waw();
        stim_t st[16];
        obs_t ea[16];
        obs_t e;
        reset_quiet();
        st = '{ins(7), ins(7) | nu1(7), ins(7), wb(7), wb(7), wb(7), '0,
               ins(7), ins(7), ins(7), ins(7), '0, wb(7), wb(7), wb(7), '0};
        ea = '{ob(0, 0, 0, 0, 0), ob(0, 0, 0, m(7), 0), ob(0, 0, 0, m(7), 0), ob(0, 0, 0, m(7), 0),
               ob(0, 0, 0, m(7), 0), ob(0, 0, 0, m(7), 0), ob(0, 0, 0, 0, 0),
               ob(0, 0, 0, 0, 0), ob(0, 0, 0, m(7), 0), ob(0, 0, 0, m(7), 0), ob(0, 0, 0, m(7), 0),
               ob(0, 0, 1, m(7), 0), ob(0, 0, 1, m(7), 0), ob(0, 0, 1, m(7), 0), ob(0, 0, 1, m(7), 0),
               ob(0, 0, 1, 0, 0)};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(ea[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL waw[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL waw_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_squash();
        stim_t st[4];
        obs_t ea[4];
        obs_t e;
        reset_quiet();
        st = '{ins(9), rd1(9) | ins(10), rd1(9) | ins(10) | sqk(9), '0};
        st[1].xwr = 1; st[1].xrd = 9;
        ea = '{ob(0, 0, 0, 0, 0), ob(1, 1, 0, m(9), 0), ob(0, 1, 0, m(9), 1), ob(0, 0, 0, 0, 1)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(ea[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL squash[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL squash_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_simultaneous();
        stim_t st[7];
        obs_t ea[7];
        obs_t e;
        reset_quiet();
        st = '{ins(4), ins(4), ins(4) | wb(4), wb(4), ins(4), ins(4) | sqk(4) | wb(4), '0};
        ea = '{ob(0, 0, 0, 0, 0), ob(0, 0, 0, m(4), 0), ob(0, 0, 0, m(4), 0), ob(0, 0, 0, m(4), 0),
               ob(0, 0, 0, m(4), 0), ob(0, 1, 0, m(4), 0), ob(0, 0, 0, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(ea[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL simul[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL simul_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_x0_midreset();
        stim_t st[8];
        obs_t ea[8];
        obs_t e;
        reset_quiet();
        st = '{ins(0) | rd1(0) | rd2(0), wb(0) | rd1(0), '0, ins(12),
               rd1(12), rd1(12) | rs(), rd1(12), '0};
        ea = '{ob(0, 0, 0, 0, 0), ob(0, 0, 0, 0, 0), ob(0, 0, 0, 0, 0), ob(0, 0, 0, 0, 0),
               ob(1, 1, 0, m(12), 0), ob(0, 0, 0, m(12), 1), ob(0, 0, 0, 0, 0), ob(0, 0, 0, 0, 0)};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1; apply(st[i]);
            exp_q.push_back(ea[i]); expb_q.push_back(ea[i]);
            @(negedge clk);
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL x0_rst[%0d] got %h want %h", i, obs_a, e); end
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL x0_rst_byp[%0d] got %h want %h", i, obs_b, e); end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_squash();
        test_simultaneous();
        test_x0_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
